// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: request and hazard-query signals (pipe_*, mc_*, rs*) and the registered reg_file write port (WE3/A3/WD3); slave faces the arbiter, master faces the surrounding pipeline
interface rf_write_arbiter_if;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wd;
  logic        pipe_stall;
  logic        mc_valid;
  logic [4:0]  mc_rd;
  logic [31:0] mc_wd;
  logic        mc_ready;
  logic        mc_issue;
  logic [4:0]  mc_issue_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        busy_rs1;
  logic        busy_rs2;
  logic        pending_any;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  modport slave (
    input  pipe_we, pipe_rd, pipe_wd, mc_valid, mc_rd, mc_wd, mc_issue, mc_issue_rd, rs1, rs2,
    output pipe_stall, mc_ready, busy_rs1, busy_rs2, pending_any, WE3, A3, WD3
  );
  modport master (
    output pipe_we, pipe_rd, pipe_wd, mc_valid, mc_rd, mc_wd, mc_issue, mc_issue_rd, rs1, rs2,
    input  pipe_stall, mc_ready, busy_rs1, busy_rs2, pending_any, WE3, A3, WD3
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: arbitrates the reg_file write port between pipeline writeback and a multi-cycle unit, with a RAW scoreboard; ports clk, rst (sync active-high), bus (rf_write_arbiter_if.slave); define RF_ARB_STARVE_EN to enable the starvation counter that forces the pipeline to yield after STARVE_LIMIT refusals
module rf_write_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic rst,
  rf_write_arbiter_if.slave bus
);
  logic [31:0] pending, pend_n;
  logic        force_q, mc_xfer, pipe_take, win_we;
  logic [4:0]  win_rd;
  logic [31:0] win_wd;
  assign bus.mc_ready    = ~rst & bus.mc_valid & (force_q | ~bus.pipe_we);
  assign bus.pipe_stall  = ~rst & force_q;
  assign mc_xfer         = bus.mc_valid & bus.mc_ready;
  assign pipe_take       = ~rst & bus.pipe_we & ~force_q;
  assign win_rd          = mc_xfer ? bus.mc_rd : bus.pipe_rd;
  assign win_wd          = mc_xfer ? bus.mc_wd : bus.pipe_wd;
  assign win_we          = (mc_xfer | pipe_take) & (|win_rd);
  assign pend_n          = (pending & ~(mc_xfer ? 32'd1 << bus.mc_rd : 32'd0))
                         | ((bus.mc_issue && bus.mc_issue_rd != 5'd0) ? 32'd1 << bus.mc_issue_rd : 32'd0);
  assign bus.busy_rs1    = pending[bus.rs1];
  assign bus.busy_rs2    = pending[bus.rs2];
  assign bus.pending_any = |pending;
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.WE3 <= 1'b0;
      bus.A3  <= '0;
      bus.WD3 <= '0;
      pending <= '0;
    end else begin
      bus.WE3 <= win_we;
      pending <= pend_n;
      if (win_we) begin
        bus.A3  <= win_rd;
        bus.WD3 <= win_wd;
      end
    end
  end
`ifdef RF_ARB_STARVE_EN
  logic [CNT_W-1:0] cnt;
  logic             refused;
  assign refused = bus.mc_valid & ~bus.mc_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      force_q <= 1'b0;
    end else begin
      cnt     <= refused ? cnt + 1'b1 : '0;
      force_q <= refused && cnt == CNT_W'(STARVE_LIMIT - 1);
    end
  end
`else
  assign force_q = 1'b0;
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: randomized scoreboard bench for rf_write_arbiter against a behavioural model of the arbitration, scoreboard and starvation rules
module tb_rf_write_arbiter;
  localparam int LIMIT = 4;
`ifdef RF_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  rf_write_arbiter_if bus();
  rf_write_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {bit we; bit [4:0] a; bit [31:0] wd;} wr_t;
  wr_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  bit done = 1'b0;
  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask
  bit        pend[32];
  int        streak = 0;
  bit        frc = 1'b0;
  bit        f, rdy, has, any;
  bit [4:0]  hold_a = '0, w_rd;
  bit [31:0] hold_wd = '0, w_wd;
  wr_t       e;
  always @(negedge clk) if (!done) begin
    if (rst) begin
      check("mc_ready_in_rst", 32'(bus.mc_ready), 32'd0);
      check("pipe_stall_in_rst", 32'(bus.pipe_stall), 32'd0);
      foreach (pend[i]) pend[i] = 1'b0;
      streak = 0;
      frc = 1'b0;
      hold_a = '0;
      hold_wd = '0;
      e = '{1'b0, 5'd0, 32'd0};
    end else begin
      f = STARVE_EN && frc;
      rdy = bus.mc_valid && (f || !bus.pipe_we);
      any = 1'b0;
      foreach (pend[i]) any |= pend[i];
      check("mc_ready", 32'(bus.mc_ready), 32'(rdy));
      check("pipe_stall", 32'(bus.pipe_stall), 32'(f));
      check("busy_rs1", 32'(bus.busy_rs1), 32'(bus.rs1 != 0 && pend[bus.rs1]));
      check("busy_rs2", 32'(bus.busy_rs2), 32'(bus.rs2 != 0 && pend[bus.rs2]));
      check("pending_any", 32'(bus.pending_any), 32'(any));
      has = 1'b1;
      if (bus.mc_valid && rdy) begin
        w_rd = bus.mc_rd;
        w_wd = bus.mc_wd;
      end else if (bus.pipe_we && !f) begin
        w_rd = bus.pipe_rd;
        w_wd = bus.pipe_wd;
      end else begin
        has = 1'b0;
        w_rd = '0;
        w_wd = '0;
      end
      e.we = has && w_rd != 0;
      if (e.we) begin
        hold_a = w_rd;
        hold_wd = w_wd;
      end
      e.a = hold_a;
      e.wd = hold_wd;
      if (bus.mc_valid && rdy) pend[bus.mc_rd] = 1'b0;
      if (bus.mc_issue && bus.mc_issue_rd != 0) pend[bus.mc_issue_rd] = 1'b1;
      streak = (bus.mc_valid && !rdy) ? streak + 1 : 0;
      frc = streak >= LIMIT;
    end
    exp_q.push_back(e);
  end
  int  mcyc = 0;
  wr_t m_e;
  always @(negedge clk) if (!done) begin
    if (mcyc > 0) begin
      if (exp_q.size() == 0) check("queue_underflow", 32'd1, 32'd0);
      else begin
        m_e = exp_q.pop_front();
        check("WE3", 32'(bus.WE3), 32'(m_e.we));
        check("A3", 32'(bus.A3), 32'(m_e.a));
        check("WD3", bus.WD3, m_e.wd);
      end
    end
    mcyc++;
  end
  bit consumed, accepted;
  initial begin
    bus.pipe_we = 1'b0; bus.pipe_rd = '0; bus.pipe_wd = '0;
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd3; bus.mc_wd = 32'hDEAD0003;
    bus.mc_issue = 1'b0; bus.mc_issue_rd = '0; bus.rs1 = '0; bus.rs2 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.pipe_we = 1'b1; bus.pipe_rd = 5'd5; bus.pipe_wd = 32'hAAAA0001;
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd6; bus.mc_wd = 32'h12345678;
    bus.mc_issue = 1'b1; bus.mc_issue_rd = 5'd9; bus.rs1 = 5'd9; bus.rs2 = 5'd0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      consumed = bus.pipe_we && !bus.pipe_stall && !rst;
      accepted = bus.mc_valid && bus.mc_ready;
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 199) == 0);
      if (!(bus.pipe_we && !consumed)) begin
        bus.pipe_we = $urandom_range(0, 9) < 7;
        bus.pipe_rd = 5'($urandom_range(0, 11));
        bus.pipe_wd = $urandom;
      end
      if (bus.mc_valid && !accepted) begin
        if ($urandom_range(0, 19) == 0) bus.mc_valid = 1'b0;
      end else begin
        bus.mc_valid = $urandom_range(0, 9) < 4;
        bus.mc_rd = 5'($urandom_range(0, 11));
        bus.mc_wd = $urandom;
      end
      bus.mc_issue = $urandom_range(0, 4) == 0;
      bus.mc_issue_rd = 5'($urandom_range(0, 11));
      bus.rs1 = 5'($urandom_range(0, 11));
      bus.rs2 = 5'($urandom_range(0, 11));
    end
    repeat (2) @(negedge clk);
    #1;
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Sequences the single register-file write port (WE3/A3/WD3) between two writers: the in-order pipeline writeback stage and a multi-cycle unit (divider or miss-handling load path) with a valid/ready handshake.
- Keeps a per-register scoreboard of outstanding multi-cycle destinations so issue logic can stall on RAW hazards.
- Sits between the writeback mux and reg_file. Its write outputs are registered and wire straight onto reg_file's write port.

Parameters:
- STARVE_LIMIT, 4, consecutive cycles a valid multi-cycle request may be refused before the pipeline is forced to yield (range 1..15).
- CNT_W, 4, width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- pipe_we  input  1  pipeline writeback request this cycle.
- pipe_rd  input  5  pipeline destination register.
- pipe_wd  input  32  pipeline write data.
- pipe_stall  output  1  pipeline request not consumed this cycle; upstream holds pipe_we/rd/wd stable.
- mc_valid  input  1  multi-cycle unit has a result.
- mc_rd  input  5  multi-cycle destination register.
- mc_wd  input  32  multi-cycle result data.
- mc_ready  output  1  multi-cycle result accepted this cycle.
- mc_issue  input  1  one-cycle pulse: multi-cycle op issued.
- mc_issue_rd  input  5  destination of the issued op.
- rs1  input  5  hazard query address 1.
- rs2  input  5  hazard query address 2.
- busy_rs1  output  1  rs1 has an outstanding multi-cycle write.
- busy_rs2  output  1  rs2 has an outstanding multi-cycle write.
- pending_any  output  1  OR of all scoreboard bits.
- WE3  output  1  reg_file write enable (registered).
- A3  output  5  reg_file write address (registered).
- WD3  output  32  reg_file write data (registered).

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - WE3=0, A3=0, WD3=0.
  - pipe_stall=0.
  - Scoreboard cleared, starvation counter=0, force flag=0.
  - While rst=1, mc_ready=0.
  - An in-flight multi-cycle result is dropped; the multi-cycle unit is reset by the same rst.
- Arbitration, evaluated each cycle:
  - force=0: pipeline has strict priority. mc_ready = mc_valid & ~pipe_we.
  - force=1: pipe_stall=1, mc_ready = mc_valid, and the pipeline request is not consumed.
- Handshake: a transfer occurs when mc_valid & mc_ready. mc_rd and mc_wd must stay stable while mc_valid=1 and mc_ready=0.
- Write latency is one cycle. The winner's address and data register into A3/WD3 at the next edge, and WE3 is asserted for exactly one cycle.
- Writes to x0:
  - A winner with rd=0 completes its handshake or consumption normally.
  - WE3 is registered as 0 and A3/WD3 hold their previous values.
- No writer this cycle: WE3=0 next cycle, A3/WD3 hold.
- Starvation counter:
  - Increments on each cycle with mc_valid=1 and mc_ready=0.
  - Clears on any mc transfer, and on any cycle with mc_valid=0.
  - When the counter equals STARVE_LIMIT-1 and the request is refused again, force is set for the next cycle.
- Force flag:
  - Lasts exactly one cycle, then clears.
  - If mc_valid drops during the force cycle, that cycle is idle: pipe_stall=1 and WE3=0 next cycle.
- Scoreboard (32 pending bits, bit 0 is always 0):
  - mc_issue with mc_issue_rd!=0 sets pending[mc_issue_rd] at the next edge.
  - An mc transfer clears pending[mc_rd] at the next edge.
  - Set and clear of the same register in the same cycle: set wins.
- Hazard outputs:
  - busy_rs1 = pending[rs1] and busy_rs2 = pending[rs2], both combinational; rs=0 always gives 0.
  - Pending bits reflect state after the edge, with no bypass of same-cycle issue.
- A pipe_we targeting a pending register is an upstream error. It is not checked and the write proceeds.

Optional Feature:
- Macro: RF_ARB_STARVE_EN.
- Defined: starvation counter and force behaviour as above.
- Undefined:
  - Counter and force logic are removed and pipe_stall is tied 0.
  - The pipeline always wins, and mc_ready = mc_valid & ~pipe_we.
  - STARVE_LIMIT and CNT_W are unused.

Test Plan:
1. Reset and idle. Assert rst for 2 cycles with mc_valid=1, then release with all requests idle -> during rst mc_ready=0; throughout, WE3=0, A3=0, WD3=0, pending_any=0, pipe_stall=0.
2. Collision. pipe_we=1, pipe_rd=5, pipe_wd=0xAAAA0001 together with mc_valid=1, mc_rd=6, mc_wd=0x12345678 for one cycle -> mc_ready=0; next cycle WE3=1, A3=5, WD3=0xAAAA0001. Drop pipe_we the following cycle -> mc_ready=1; one cycle later WE3=1, A3=6, WD3=0x12345678.
3. Starvation (RF_ARB_STARVE_EN, STARVE_LIMIT=4). pipe_we=1 every cycle with rd 1..9, mc_valid=1 with mc_rd=7 -> refused for 4 cycles; 5th cycle pipe_stall=1 and mc_ready=1; next cycle A3=7 and the held pipeline rd is written the cycle after.
4. Scoreboard. Pulse mc_issue with mc_issue_rd=9, then query rs1=9, rs2=0 -> busy_rs1=1, busy_rs2=0, pending_any=1. Complete the mc transfer with mc_rd=9 -> next cycle busy_rs1=0, pending_any=0. Same-cycle issue rd=9 plus transfer rd=9 -> pending[9] stays 1.
5. x0 writes. pipe_we=1, pipe_rd=0, then mc transfer with mc_rd=0 -> WE3 stays 0; A3/WD3 unchanged. mc_issue with mc_issue_rd=0 -> pending_any stays 0.
6. Reset mid-operation. pending[3]=1, counter=2, mc_valid=1, then rst for 1 cycle -> pending_any=0, WE3=0, pipe_stall=0; after release, 3 more refused cycles do not assert force.
